// File: rtl/wrr_packet_arbiter_if.sv
// Request/response bundle for wrr_packet_arbiter: NREQ sources in, one stream out.
// Handshake: a beat moves when valid & ready are high in the same cycle; a source
// holds valid (and its fields) until it sees ready; ready may depend on valid.
interface wrr_packet_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 4
);
  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ*WEIGHT_W-1:0] weight;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_last;
  logic [NREQ*DATA_W-1:0]   req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     out_valid;
  logic                     out_last;
  logic [DATA_W-1:0]        out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_ready;
  logic [NREQ-1:0]          grant;

  modport slave (
    input  weight, req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_last, out_data, out_idx, grant
  );

  modport master (
    output weight, req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_last, out_data, out_idx, grant
  );
endinterface

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter: a source keeps the grant for a whole packet
// and for up to weight[i] consecutive packets before priority moves past it.
module wrr_packet_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  wrr_packet_arbiter_if.slave      bus,
  output logic                     dbg_state,
  output logic [$clog2(NREQ)-1:0]  dbg_ptr,
  output logic [WEIGHT_W-1:0]      dbg_credit,
  output logic [$clog2(NREQ)-1:0]  dbg_lock_idx
);
  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    ptr, ptr_n, lock_idx, lock_n, win;
  logic [WEIGHT_W-1:0] credit, credit_n, wsel, wnext;
  logic [WEIGHT_W:0]   ew, used, ew_next;
  logic [IDX_W:0]      scan, inc;
  logic                found, xfer, last_s;
  logic [NREQ-1:0]     grant_s;

  // Winner selection: LOCKED pins the winner, IDLE scans from ptr with wrap.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    scan  = '0;
    if (state == LOCKED) begin
      win   = lock_idx;
      found = bus.req_valid[lock_idx];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        scan = {1'b0, ptr} + (IDX_W+1)'(k);
        if (scan >= (IDX_W+1)'(NREQ)) scan = scan - (IDX_W+1)'(NREQ);
        if (!found && bus.req_valid[scan[IDX_W-1:0]]) begin
          found = 1'b1;
          win   = scan[IDX_W-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_s = '0;
    if (found) grant_s[win] = 1'b1;
    last_s = found & bus.req_last[win];
  end

  assign bus.grant     = grant_s;
  assign bus.out_valid = found;
  assign bus.out_last  = last_s;
  assign bus.out_data  = found ? bus.req_data[win*DATA_W +: DATA_W] : '0;
  assign bus.out_idx   = found ? win : '0;
  assign bus.req_ready = grant_s & {NREQ{bus.out_ready}};

  assign xfer = found & bus.out_ready;

  // Credit accounting: credit only accumulates while the winner is the pointer owner.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    credit_n = credit;
    lock_n   = lock_idx;
    wsel     = bus.weight[win*WEIGHT_W +: WEIGHT_W];
    ew       = (wsel == '0) ? (WEIGHT_W+1)'(1) : {1'b0, wsel};
    used     = ((win == ptr) ? {1'b0, credit} : '0) + (WEIGHT_W+1)'(1);
    inc      = {1'b0, win} + (IDX_W+1)'(1);
    if (inc >= (IDX_W+1)'(NREQ)) inc = '0;
    if (xfer) begin
      if (!last_s) begin
        state_n = LOCKED;
        lock_n  = win;
      end else begin
        state_n = IDLE;
        if (used >= ew) begin
          ptr_n    = inc[IDX_W-1:0];
          credit_n = '0;
        end else begin
          ptr_n    = win;
          credit_n = used[WEIGHT_W-1:0];
        end
      end
    end
    wnext   = bus.weight[ptr_n*WEIGHT_W +: WEIGHT_W];
    ew_next = (wnext == '0) ? (WEIGHT_W+1)'(1) : {1'b0, wnext};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      credit   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      credit   <= credit_n;
      lock_idx <= lock_n;
    end
  end

  assign dbg_state    = (state == LOCKED);
  assign dbg_ptr      = ptr;
  assign dbg_credit   = credit;
  assign dbg_lock_idx = lock_idx;

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ($onehot0(grant_s));
      if (state == LOCKED) assert ((grant_s & ~(NREQ'(1) << lock_idx)) == '0);
      if (xfer && last_s) assert ({1'b0, credit_n} < ew_next);
    end
  end
endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Directed bench for wrr_packet_arbiter: hand-computed beats go into a queue,
// a negedge monitor pops and compares every transferred beat.
module tb_wrr_packet_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int WW   = 4;
  localparam int EW   = 2 + 1 + DW;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dbg_state;
  logic [1:0] dbg_ptr, dbg_lock_idx;
  logic [3:0] dbg_credit;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [EW-1:0] exp_q[$];

  wrr_packet_arbiter_if #(.NREQ(NREQ), .DATA_W(DW), .WEIGHT_W(WW)) bus ();

  wrr_packet_arbiter #(.NREQ(NREQ), .DATA_W(DW), .WEIGHT_W(WW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .dbg_state    (dbg_state),
    .dbg_ptr      (dbg_ptr),
    .dbg_credit   (dbg_credit),
    .dbg_lock_idx (dbg_lock_idx)
  );

  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] dat(input int src, input int beat);
    return 32'hD000_0000 | DW'(src << 8) | DW'(beat);
  endfunction

  task automatic push(input int src, input logic last, input int beat);
    exp_q.push_back({2'(src), last, dat(src, beat)});
  endtask

  task automatic set_src(input int src, input logic v, input logic last, input int beat);
    bus.req_valid[src] = v;
    bus.req_last[src]  = last;
    bus.req_data[src*DW +: DW] = v ? dat(src, beat) : '0;
  endtask

  task automatic clear_srcs();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
  endtask

  // One clock cycle: check grant mid-cycle, then advance past the edge.
  task automatic cyc(input string name, input logic [3:0] exp_grant);
    @(negedge clock);
    check(name, 64'(bus.grant), 64'(exp_grant));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_srcs();
    bus.out_ready = 1'b0;
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_beat: got idx %0d data 0x%0h expected no transfer",
                 bus.out_idx, bus.out_data);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("beat", 64'({bus.out_idx, bus.out_last, bus.out_data}), 64'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int seq2[9];
    seq2 = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    bus.weight = '0;
    bus.out_ready = 1'b0;
    clear_srcs();

    do_reset();
    @(negedge clock);
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_idx", 64'(bus.out_idx), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_ptr", 64'(dbg_ptr), 64'd0);
    check("rst_credit", 64'(dbg_credit), 64'd0);
    @(posedge clock);
    #1;

    // 1: equal weights, single-beat packets rotate every cycle
    do_reset();
    for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, 1'b1, 0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      push(c % 4, 1'b1, 0);
      cyc("t1_grant", 4'(1 << (c % 4)));
    end

    // 2: weight0 = 3 gives source 0 three packets per turn
    do_reset();
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, 1'b1, 0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      push(seq2[c], 1'b1, 0);
      cyc("t2_grant", 4'(1 << seq2[c]));
    end

    // 3: three-beat packet on src0 with a stall; src1 waits
    do_reset();
    set_src(0, 1'b1, 1'b0, 0);
    set_src(1, 1'b1, 1'b1, 0);
    bus.out_ready = 1'b1;
    push(0, 1'b0, 0);
    cyc("t3_beat0", 4'b0001);
    bus.out_ready = 1'b0;
    @(negedge clock);
    check("t3_stall_ready", 64'(bus.req_ready), 64'd0);
    cyc("t3_stall", 4'b0001);
    bus.out_ready = 1'b1;
    set_src(0, 1'b1, 1'b0, 1);
    push(0, 1'b0, 1);
    cyc("t3_beat1", 4'b0001);
    set_src(0, 1'b1, 1'b1, 2);
    push(0, 1'b1, 2);
    cyc("t3_beat2", 4'b0001);
    set_src(0, 1'b0, 1'b0, 0);
    push(1, 1'b1, 0);
    cyc("t3_src1", 4'b0010);

    // 4: lock on src2 survives a valid gap while src0 is requesting
    do_reset();
    bus.out_ready = 1'b1;
    set_src(2, 1'b1, 1'b0, 0);
    push(2, 1'b0, 0);
    cyc("t4_first", 4'b0100);
    set_src(2, 1'b0, 1'b0, 0);
    set_src(0, 1'b1, 1'b1, 0);
    @(negedge clock);
    check("t4_gap_valid", 64'(bus.out_valid), 64'd0);
    check("t4_locked", 64'(dbg_state), 64'd1);
    cyc("t4_gap1", 4'b0000);
    cyc("t4_gap2", 4'b0000);
    set_src(2, 1'b1, 1'b1, 1);
    push(2, 1'b1, 1);
    cyc("t4_resume", 4'b0100);
    set_src(2, 1'b0, 1'b0, 0);
    push(0, 1'b1, 0);
    cyc("t4_src0", 4'b0001);
    clear_srcs();

    // 5: weight 0 behaves as 1; src2 wins from ptr 0 and rotates to 3
    do_reset();
    bus.weight = {4'd1, 4'd0, 4'd1, 4'd1};
    bus.out_ready = 1'b1;
    set_src(2, 1'b1, 1'b1, 0);
    set_src(3, 1'b1, 1'b1, 0);
    push(2, 1'b1, 0);
    cyc("t5_grant", 4'b0100);
    clear_srcs();
    @(negedge clock);
    check("t5_ptr", 64'(dbg_ptr), 64'd3);
    check("t5_credit", 64'(dbg_credit), 64'd0);
    @(posedge clock);
    #1;

    // 6: reset in the middle of a locked packet on src3
    do_reset();
    bus.out_ready = 1'b1;
    set_src(3, 1'b1, 1'b0, 0);
    push(3, 1'b0, 0);
    cyc("t6_lock", 4'b1000);
    for (int i = 0; i < NREQ; i++) set_src(i, 1'b1, 1'b1, 1);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("t6_state", 64'(dbg_state), 64'd0);
    check("t6_ptr", 64'(dbg_ptr), 64'd0);
    check("t6_grant", 64'(bus.grant), 64'b0001);
    @(posedge clock);
    #1;
    clear_srcs();

    // drain: every expected beat must have been observed
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clock);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
